nvme_buffer_ram_pipe: RTL

Parametrised single-clock successor to the NVMe data-buffer RAM, used for command/PRP staging between the PCIe and AXI sides.
- Generic data width split into byte-lane-style write lanes.
- Selectable read latency (1 or 2) with an output valid strobe.
- Defined write-first bypass on same-address collisions.
- Optional per-lane parity protection.

---
 rtl/nvme_buffer_pkg.sv | 30 +++
 rtl/nvme_buffer_lane.sv | 93 +++++++++
 rtl/nvme_buffer_ram_pipe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/nvme_buffer_pkg.sv
// Shared definitions for the NVMe data-buffer RAM pipeline.
// Contents: lane-count helper, even-parity helper, and the read-pipeline
// control word carried alongside each read.
// Optional feature macro used by the files that import this package:
// NVME_BUF_PARITY_EN.
package nvme_buffer_pkg;

    // Largest lane width the parity helper accepts.
    localparam int unsigned MAX_LANE_WIDTH = 256;

    // Control part of a read-pipeline entry. The data and per-lane error
    // fields depend on module parameters, so the full entry is declared
    // by the top around this type.
    typedef struct packed {
        logic valid;
        logic collision;
    } pipe_ctrl_t;

    // Number of write-enable lanes in a word.
    function automatic int unsigned lanes(input int unsigned data_width,
                                          input int unsigned lane_width);
        return (lane_width == 0) ? 0 : data_width / lane_width;
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [MAX_LANE_WIDTH-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/nvme_buffer_lane.sv
// One write lane of the NVMe data buffer: storage array, optional parity
// bit per word, lane write enable, and the stage-1 read register.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   we            lane write enable
//   waddr, din    write address and lane write data
//   inj_err       invert the stored parity of this write
//   re, raddr     read request and address
//   bypass        return din instead of stored data (same-cycle collision)
//   rdata         stage-1 read data (holds when no read)
//   err_c         parity mismatch that stage 1 will capture on this edge
//   err           stage-1 registered parity mismatch (0 when no read)
// Macro: NVME_BUF_PARITY_EN enables the parity bit storage and checking.
module nvme_buffer_lane
    import nvme_buffer_pkg::*;
#(
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [LANE_WIDTH-1:0] din,
    input  logic                  inj_err,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    input  logic                  bypass,
    output logic [LANE_WIDTH-1:0] rdata,
    output logic                  err_c,
    output logic                  err
);

    localparam int unsigned AW1   = ADDR_BITS + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                  w_ok;
    logic                  r_ok;
    logic [IDX_W-1:0]      widx;
    logic [IDX_W-1:0]      ridx;
    logic [LANE_WIDTH-1:0] stored;
    logic [LANE_WIDTH-1:0] mem [DEPTH];

    // Address range qualification; out-of-range writes are dropped.
    assign w_ok   = we && ({1'b0, waddr} < AW1'(DEPTH));
    assign r_ok   = {1'b0, raddr} < AW1'(DEPTH);
    assign widx   = IDX_W'(waddr);
    assign ridx   = IDX_W'(raddr);
    assign stored = r_ok ? mem[ridx] : '0;

    // Lane storage (not reset).
    always_ff @(posedge clk) begin
        if (w_ok) begin
            mem[widx] <= din;
        end
    end

`ifdef NVME_BUF_PARITY_EN
    logic par [DEPTH];

    // Parity bit stored with the word; inj_err corrupts it on purpose.
    always_ff @(posedge clk) begin
        if (w_ok) begin
            par[widx] <= even_parity(MAX_LANE_WIDTH'(din)) ^ inj_err;
        end
    end

    // Bypassed lanes return fresh write data, so they never flag.
    assign err_c = re && r_ok && !bypass &&
                   (even_parity(MAX_LANE_WIDTH'(stored)) != par[ridx]);
`else
    logic unused_inj;

    assign unused_inj = inj_err;
    assign err_c      = 1'b0;
`endif

    // Stage-1 read register; data is captured here so later writes do not
    // disturb a read already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            err <= err_c;
            if (re) begin
                rdata <= bypass ? din : stored;
            end
        end
    end

endmodule

// File: rtl/nvme_buffer_ram_pipe.sv
// NVMe data-buffer RAM with lane writes, 1- or 2-cycle read pipeline,
// write-first bypass on same-address collisions and optional lane parity.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   we, waddr, din    per-lane write enable, write address, write data
//   re, raddr         read request and address
//   dout, dout_valid  read data and its one-cycle valid strobe
//   collision         read hit a same-cycle write to the same address
//   inj_err, err_clr  parity error injection and sticky error clear
//   parity_err_lanes  per-lane mismatch, qualified by dout_valid
//   parity_err        sticky OR of mismatches
// Macro: NVME_BUF_PARITY_EN enables parity storage and error reporting;
// without it the parity outputs are tied low.
module nvme_buffer_ram_pipe
    import nvme_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 8,
    parameter int unsigned DEPTH      = 2 ** ADDR_BITS,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned LANES     = lanes(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  collision,
    input  logic                  inj_err,
    input  logic                  err_clr,
    output logic [LANES-1:0]      parity_err_lanes,
    output logic                  parity_err
);

    // Parameter legality.
    if (LANE_WIDTH == 0 || (DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane
        $error("nvme_buffer_ram_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (LANE_WIDTH > MAX_LANE_WIDTH) begin : g_bad_lane_width
        $error("nvme_buffer_ram_pipe: LANE_WIDTH exceeds MAX_LANE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("nvme_buffer_ram_pipe: RD_LATENCY must be 1 or 2");
    end
    if (DEPTH > 2 ** ADDR_BITS) begin : g_bad_depth
        $error("nvme_buffer_ram_pipe: DEPTH exceeds 2**ADDR_BITS");
    end

    localparam int unsigned AW1 = ADDR_BITS + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        pipe_ctrl_t            ctrl;
        logic [LANES-1:0]      err;
    } pipe_entry_t;

    logic                  hit_c;
    logic [LANES-1:0]      bypass_c;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [LANES-1:0]      s1_err;
    logic [LANES-1:0]      s1_err_c;
    pipe_ctrl_t            s1_ctrl;
    pipe_entry_t           s1;
    pipe_entry_t           out;
    logic [LANES-1:0]      err_next_c;

    // Same-cycle read/write of one in-range word: written lanes bypass.
    assign hit_c    = re && (|we) && (raddr == waddr) && ({1'b0, waddr} < AW1'(DEPTH));
    assign bypass_c = we & {LANES{hit_c}};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        nvme_buffer_lane #(
            .LANE_WIDTH (LANE_WIDTH),
            .ADDR_BITS  (ADDR_BITS),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we      (we[i]),
            .waddr   (waddr),
            .din     (din[i*LANE_WIDTH +: LANE_WIDTH]),
            .inj_err (inj_err),
            .re      (re),
            .raddr   (raddr),
            .bypass  (bypass_c[i]),
            .rdata   (s1_data[i*LANE_WIDTH +: LANE_WIDTH]),
            .err_c   (s1_err_c[i]),
            .err     (s1_err[i])
        );
    end

    // Stage-1 control bits travel with the lane read registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ctrl <= '0;
        end else begin
            s1_ctrl.valid     <= re;
            s1_ctrl.collision <= hit_c;
        end
    end

    assign s1.data = s1_data;
    assign s1.ctrl = s1_ctrl;
    assign s1.err  = s1_err;

    if (RD_LATENCY == 2) begin : g_lat2
        pipe_entry_t s2;
        logic        unused_err_c;

        // Stage 2: data only advances on a valid read so dout holds.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2 <= '0;
            end else begin
                s2.ctrl <= s1.ctrl;
                s2.err  <= s1.err;
                if (s1.ctrl.valid) begin
                    s2.data <= s1.data;
                end
            end
        end

        assign out          = s2;
        assign err_next_c   = s1.err;
        assign unused_err_c = ^s1_err_c;
    end else begin : g_lat1
        assign out        = s1;
        assign err_next_c = s1_err_c;
    end

    assign dout       = out.data;
    assign dout_valid = out.ctrl.valid;
    assign collision  = out.ctrl.collision;

`ifdef NVME_BUF_PARITY_EN
    // Sticky error rises together with parity_err_lanes; a new error beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= (|err_next_c) || (parity_err && !err_clr);
        end
    end

    assign parity_err_lanes = out.err;
`else
    logic unused_par;

    assign unused_par       = ^{err_clr, err_next_c, out.err};
    assign parity_err       = 1'b0;
    assign parity_err_lanes = '0;
`endif

endmodule
